dlx_mem_arbiter: RTL and testbench
==================================

DLX_MEM_ARBITER -- requirements
Module: dlx_mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, 32, data/instruction word width.
REQ-002 Parameter INST_ADDR_WIDTH, 20, instruction address width.
REQ-003 Parameter DATA_ADDR_WIDTH, 32, data address and memory address width.
REQ-004 Parameter TIMEOUT, 16, maximum wait cycles for mem_ack (legal range 2..255).
REQ-005 The block SHALL have one clock, clk; reset, rst, SHALL be asynchronous and active-high.
REQ-006 Ports, one per line (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  async active-high reset.
- instr_rd_en  in  1  instruction fetch request.
- instr_addr  in  INST_ADDR_WIDTH  fetch address.
- instruction  out  DATA_WIDTH  fetched word.
- instr_valid  out  1  one-cycle fetch-complete pulse.
- data_rd_en  in  1  load request.
- data_wr_en  in  1  store request.
- data_addr  in  DATA_ADDR_WIDTH  load/store address.
- data_write  in  DATA_WIDTH  store data.
- data_read  out  DATA_WIDTH  load data.
- data_valid  out  1  one-cycle load/store-complete pulse.
- mem_req  out  1  shared memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  DATA_ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completion strobe.
- stall  out  1  pipeline stall to the core.
- bus_err  out  1  sticky timeout flag.

Function
REQ-007 States SHALL be IDLE, GRANT_I, GRANT_D; GRANT_I/GRANT_D are together the busy states.
REQ-008 Requesters hold request and address stable until their valid pulse; the arbiter samples requests only in IDLE.
REQ-009 In IDLE with one request pending, the arbiter SHALL enter the matching grant state next cycle; data request = data_rd_en | data_wr_en.
REQ-010 With both pending in IDLE, grant SHALL go to the port not granted last (last_grant register, reset = instruction, so data wins first).
REQ-011 On grant, instr_addr (zero-extended to DATA_ADDR_WIDTH), data_addr, data_write and the write flag SHALL be registered; mem_* SHALL be driven from these registers only.
REQ-012 mem_req SHALL be 1 in every busy-state cycle and 0 in IDLE; mem_we = 1 only in GRANT_D for a store.
REQ-013 If data_rd_en and data_wr_en are both 1 at grant, the store SHALL take effect (mem_we = 1).
REQ-014 On mem_ack in a busy state: capture mem_rdata into instruction (GRANT_I) or data_read (GRANT_D, loads only; stores leave data_read unchanged), pulse the matching valid for one cycle, update last_grant, return to IDLE.
REQ-015 A wait counter SHALL clear on grant and increment each busy cycle without mem_ack; when it reaches TIMEOUT, the arbiter SHALL complete as in REQ-014 with read data forced to 0 and set bus_err.
REQ-016 bus_err SHALL remain 1 until reset.
REQ-017 mem_ack in IDLE SHALL be ignored.
REQ-018 stall SHALL be 1 whenever a request is pending without its valid pulse this cycle: (instr_rd_en & ~instr_valid) | (data request & ~data_valid).
REQ-019 Minimum latency: request in IDLE at cycle n, grant at n+1, mem_ack at n+1 gives valid at n+2; back-to-back alternating grants SHALL cost 3 cycles each.

Reset
REQ-020 While rst = 1: state IDLE; mem_req, mem_we, instr_valid, data_valid, bus_err, stall = 0; instruction, data_read, mem_addr, mem_wdata, wait counter = 0; last_grant = instruction.
REQ-021 Reset asserted mid-transaction SHALL abort it immediately with no valid pulse; the first transaction after release SHALL start from IDLE.

Verification
REQ-022 Single fetch: instr_rd_en = 1 with instr_addr = 0x40000 and mem_ack one cycle after mem_req, mem_rdata = 0x20010005 -> mem_addr = 0x00040000, mem_we = 0, instruction = 0x20010005, instr_valid pulses once, stall drops.
REQ-023 Simultaneous requests after reset: fetch 0x40004 plus store 0xDEADBEEF to address 0x100 -> store granted first (mem_we = 1, mem_wdata = 0xDEADBEEF), then fetch; data_valid precedes instr_valid by 3 cycles.
REQ-024 Fairness: both ports continuously requesting, immediate acks -> grants alternate D, I, D, I over 8 transactions, with no port granted twice in a row.
REQ-025 Timeout: load from 0x200 with mem_ack never asserted -> after TIMEOUT = 16 busy cycles, data_valid pulses, data_read = 0, bus_err = 1 and stays 1.
REQ-026 Reset mid-access: rst pulsed during GRANT_I before mem_ack -> mem_req = 0 the same cycle, no instr_valid pulse, and the next fetch completes normally.

Source files
------------

// File: rtl/dlx_mem_arbiter.sv
// Arbitrates a DLX core's instruction-fetch and load/store ports onto one shared
// memory bus. Grants alternate under contention; a stuck bus times out and sets bus_err.
module dlx_mem_arbiter #(
  parameter int DATA_WIDTH      = 32,
  parameter int INST_ADDR_WIDTH = 20,
  parameter int DATA_ADDR_WIDTH = 32,
  parameter int TIMEOUT         = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       instr_rd_en,
  input  logic [INST_ADDR_WIDTH-1:0] instr_addr,
  output logic [DATA_WIDTH-1:0]      instruction,
  output logic                       instr_valid,
  input  logic                       data_rd_en,
  input  logic                       data_wr_en,
  input  logic [DATA_ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0]      data_write,
  output logic [DATA_WIDTH-1:0]      data_read,
  output logic                       data_valid,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [DATA_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_wdata,
  input  logic [DATA_WIDTH-1:0]      mem_rdata,
  input  logic                       mem_ack,
  output logic                       stall,
  output logic                       bus_err
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

  state_t state, state_nxt;
  logic       last_grant_d;   // 1 = data port was served last
  logic       we_q;
  logic [7:0] wait_cnt;

  logic d_req, sample, grant_i, grant_d, busy, timeout_hit, done;

  assign d_req       = data_rd_en | data_wr_en;
  // Requesters still hold their request during the valid pulse, so IDLE
  // skips that cycle rather than re-granting a stale request.
  assign sample      = (state == IDLE) & ~instr_valid & ~data_valid;
  assign grant_d     = sample & d_req & (~instr_rd_en | ~last_grant_d);
  assign grant_i     = sample & instr_rd_en & ~grant_d;
  assign busy        = (state == GRANT_I) | (state == GRANT_D);
  assign timeout_hit = busy & ~mem_ack & (wait_cnt == 8'(TIMEOUT - 1));
  assign done        = busy & (mem_ack | timeout_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_d)      state_nxt = GRANT_D;
        else if (grant_i) state_nxt = GRANT_I;
      end
      GRANT_I, GRANT_D: if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_d <= 1'b0;
      we_q         <= 1'b0;
      wait_cnt     <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      instruction  <= '0;
      data_read    <= '0;
      instr_valid  <= 1'b0;
      data_valid   <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      data_valid  <= 1'b0;
      if (grant_d) begin
        mem_addr  <= data_addr;
        mem_wdata <= data_write;
        we_q      <= data_wr_en;
        wait_cnt  <= '0;
      end else if (grant_i) begin
        mem_addr  <= DATA_ADDR_WIDTH'(instr_addr);
        we_q      <= 1'b0;
        wait_cnt  <= '0;
      end else if (done) begin
        last_grant_d <= (state == GRANT_D);
        if (timeout_hit) bus_err <= 1'b1;
        if (state == GRANT_I) begin
          instruction <= timeout_hit ? '0 : mem_rdata;
          instr_valid <= 1'b1;
        end else begin
          if (!we_q) data_read <= timeout_hit ? '0 : mem_rdata;
          data_valid <= 1'b1;
        end
      end else if (busy) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

  assign mem_req = busy;
  assign mem_we  = (state == GRANT_D) & we_q;
  assign stall   = ~rst & ((instr_rd_en & ~instr_valid) | (d_req & ~data_valid));

endmodule

// File: tb/tb_dlx_mem_arbiter.sv
// Directed bench for dlx_mem_arbiter: fetch, contention, fairness, timeout, reset abort.
module tb_dlx_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_rd_en;
  logic [19:0] instr_addr;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        data_rd_en, data_wr_en;
  logic [31:0] data_addr, data_write, data_read;
  logic        data_valid;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        stall, bus_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dlx_mem_arbiter #(.DATA_WIDTH(32), .INST_ADDR_WIDTH(20), .DATA_ADDR_WIDTH(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .instr_rd_en(instr_rd_en), .instr_addr(instr_addr), .instruction(instruction), .instr_valid(instr_valid),
    .data_rd_en(data_rd_en), .data_wr_en(data_wr_en), .data_addr(data_addr), .data_write(data_write),
    .data_read(data_read), .data_valid(data_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall), .bus_err(bus_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic exp_d;
    rst = 1'b1; instr_rd_en = 1'b1; instr_addr = '0;
    data_rd_en = 1'b0; data_wr_en = 1'b0; data_addr = '0; data_write = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    tick(); tick();
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_instruction", instruction, 0);
    chk("rst_data_read", data_read, 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_bus_err", 32'(bus_err), 0);

    // single fetch, ack on the second busy cycle
    rst = 1'b0; instr_rd_en = 1'b0;
    tick();
    instr_rd_en = 1'b1; instr_addr = 20'h40000;
    #1;
    chk("f_stall_idle", 32'(stall), 1);
    chk("f_req_idle", 32'(mem_req), 0);
    tick();
    chk("f_mem_req", 32'(mem_req), 1);
    chk("f_mem_addr", mem_addr, 32'h0004_0000);
    chk("f_mem_we", 32'(mem_we), 0);
    tick();
    chk("f_still_busy", 32'(mem_req), 1);
    chk("f_no_valid_yet", 32'(instr_valid), 0);
    mem_ack = 1'b1; mem_rdata = 32'h2001_0005;
    tick();
    chk("f_valid", 32'(instr_valid), 1);
    chk("f_instruction", instruction, 32'h2001_0005);
    chk("f_stall_drop", 32'(stall), 0);
    chk("f_req_drop", 32'(mem_req), 0);
    mem_ack = 1'b0; instr_rd_en = 1'b0;
    tick();
    chk("f_valid_one_cycle", 32'(instr_valid), 0);

    // ack in IDLE must be ignored
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    chk("idle_ack_instr", instruction, 32'h2001_0005);
    chk("idle_ack_ivalid", 32'(instr_valid), 0);
    chk("idle_ack_dvalid", 32'(data_valid), 0);
    chk("idle_ack_req", 32'(mem_req), 0);
    mem_ack = 1'b0;

    // reset so data wins the first contention; rd+wr together means store
    rst = 1'b1; tick(); rst = 1'b0; tick();
    chk("rst2_instruction", instruction, 0);
    instr_rd_en = 1'b1; instr_addr = 20'h40004;
    data_rd_en = 1'b1; data_wr_en = 1'b1; data_addr = 32'h100; data_write = 32'hDEAD_BEEF;
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    tick();
    chk("c_grant_d_we", 32'(mem_we), 1);
    chk("c_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("c_addr_d", mem_addr, 32'h100);
    tick();
    chk("c_dvalid", 32'(data_valid), 1);
    chk("c_ivalid_not_yet", 32'(instr_valid), 0);
    chk("c_store_keeps_dread", data_read, 0);
    chk("c_stall_instr_pending", 32'(stall), 1);
    data_rd_en = 1'b0; data_wr_en = 1'b0;
    tick();
    chk("c_gap_idle", 32'(mem_req), 0);
    tick();
    chk("c_grant_i_addr", mem_addr, 32'h0004_0004);
    chk("c_grant_i_we", 32'(mem_we), 0);
    tick();
    chk("c_ivalid_plus3", 32'(instr_valid), 1);
    chk("c_instruction", instruction, 32'h1111_1111);
    instr_rd_en = 1'b0;
    tick();

    // fairness: both hold requests, immediate acks; last grant was I
    instr_rd_en = 1'b1; instr_addr = 20'h00005;
    data_rd_en = 1'b1; data_addr = 32'h300; mem_ack = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_d = (k % 2 == 0);
      mem_rdata = 32'hA0 + 32'(k);
      tick();
      chk("fair_grant", mem_addr, exp_d ? 32'h300 : 32'h5);
      tick();
      chk("fair_dvalid", 32'(data_valid), 32'(exp_d));
      chk("fair_ivalid", 32'(instr_valid), 32'(!exp_d));
      if (exp_d) chk("fair_dread", data_read, 32'hA0 + 32'(k));
      else       chk("fair_instr", instruction, 32'hA0 + 32'(k));
      tick();
    end
    instr_rd_en = 1'b0; data_rd_en = 1'b0; mem_ack = 1'b0;
    tick();

    // timeout on a load: 16 busy cycles, then valid with zeroed data
    chk("to_dread_before", data_read, 32'hA6);
    data_rd_en = 1'b1; data_addr = 32'h200;
    tick();
    chk("to_addr", mem_addr, 32'h200);
    for (int i = 0; i < 15; i++) tick();
    chk("to_busy16", 32'(mem_req), 1);
    chk("to_no_err_yet", 32'(bus_err), 0);
    tick();
    chk("to_dvalid", 32'(data_valid), 1);
    chk("to_dread_zero", data_read, 0);
    chk("to_bus_err", 32'(bus_err), 1);
    chk("to_req_drop", 32'(mem_req), 0);
    data_rd_en = 1'b0;
    tick(); tick();
    chk("to_err_sticky", 32'(bus_err), 1);

    // reset during GRANT_I aborts the fetch
    instr_rd_en = 1'b1; instr_addr = 20'h00007;
    tick();
    chk("ra_busy", 32'(mem_req), 1);
    rst = 1'b1;
    #1;
    chk("ra_req_async", 32'(mem_req), 0);
    chk("ra_err_clear", 32'(bus_err), 0);
    tick();
    chk("ra_no_valid", 32'(instr_valid), 0);
    rst = 1'b0;
    tick();
    chk("ra_regrant_addr", mem_addr, 32'h7);
    chk("ra_regrant_req", 32'(mem_req), 1);
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    chk("ra_valid", 32'(instr_valid), 1);
    chk("ra_instruction", instruction, 32'h1234_5678);
    instr_rd_en = 1'b0; mem_ack = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
